// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: per-kij sequencer for the ROW x COL weight-stationary array.
// Each kernel position runs weight load, one bubble cycle, activation streaming,
// array drain and partial-sum read-out; the bench-level handshake is start/busy/done.
// Optional macro SYSTOLIC_SEQ_PERF_EN adds the stall_cycles performance counter.
module systolic_seq_ctrl #(
  parameter int ROW     = 4,
  parameter int COL     = 4,
  parameter int NUM_INP = 8,
  parameter int KIJ_LEN = 9,
  parameter int ADDR_W  = 11,
  localparam int CNT_W  = $clog2((((ROW + COL) > NUM_INP) ? (ROW + COL) : NUM_INP) + 1),
  localparam int KIJ_W  = (KIJ_LEN > 1) ? $clog2(KIJ_LEN) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] act_base,
  output logic              busy,
  output logic              sram_rd,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [1:0]        inst_w,
  output logic              mode,
  output logic              ofifo_rd,
  output logic              psum_wr,
  output logic [ADDR_W-1:0] psum_addr,
  output logic [KIJ_W-1:0]  kij,
`ifdef SYSTOLIC_SEQ_PERF_EN
  output logic [31:0]       stall_cycles,
`endif
  output logic              iter_done,
  output logic              compute_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_GAP, S_EXEC, S_DRAIN, S_RDOUT, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(ROW - 1);
  localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(NUM_INP - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(ROW + COL - 1);
  localparam logic [KIJ_W-1:0] KIJ_LAST   = KIJ_W'(KIJ_LEN - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [KIJ_W-1:0]    kij_q, kij_d;
  logic [ADDR_W-1:0]   w_base_q, act_base_q;
  logic                latch;
  logic                stall_eff;
  logic [ADDR_W-1:0]   kij_ext, cnt_ext, w_addr, a_addr;

  // Stall only freezes the states that move data; GAP/DRAIN/IDLE/DONE run through it.
  assign stall_eff = stall && ((state_q == S_LOAD_W) || (state_q == S_EXEC) ||
                               (state_q == S_RDOUT));

  assign kij_ext   = ADDR_W'(kij_q);
  assign cnt_ext   = ADDR_W'(cnt_q);
  assign w_addr    = w_base_q + kij_ext * ADDR_W'(ROW) + cnt_ext;
  assign a_addr    = act_base_q + cnt_ext;
  assign psum_addr = kij_ext * ADDR_W'(NUM_INP) + cnt_ext;
  assign kij       = kij_q;

  // State, counters and latched base addresses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      kij_q      <= '0;
      w_base_q   <= '0;
      act_base_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kij_q   <= kij_d;
      if (latch) begin
        w_base_q   <= w_base;
        act_base_q <= act_base;
      end
    end
  end

  // Next-state logic and output decode from state, cnt, kij and stall.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    kij_d        = kij_q;
    latch        = 1'b0;
    busy         = (state_q != S_IDLE);
    sram_rd      = 1'b0;
    sram_addr    = '0;
    inst_w       = 2'b00;
    mode         = 1'b0;
    ofifo_rd     = 1'b0;
    iter_done    = 1'b0;
    compute_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          latch   = 1'b1;
          cnt_d   = '0;
          kij_d   = '0;
          state_d = S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        sram_addr = w_addr;
        if (!stall_eff) begin
          sram_rd = 1'b1;
          inst_w  = 2'b01;
          if (cnt_q == LOAD_LAST) begin
            cnt_d   = '0;
            state_d = S_GAP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_GAP: begin
        inst_w  = 2'b01;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        mode      = 1'b1;
        sram_addr = a_addr;
        if (!stall_eff) begin
          sram_rd = 1'b1;
          inst_w  = 2'b10;
          if (cnt_q == EXEC_LAST) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        mode = 1'b1;
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = S_RDOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RDOUT: begin
        mode = 1'b1;
        if (!stall_eff) begin
          ofifo_rd = 1'b1;
          if (cnt_q == EXEC_LAST) begin
            iter_done = 1'b1;
            cnt_d     = '0;
            if (kij_q == KIJ_LAST) begin
              kij_d   = '0;
              state_d = S_DONE;
            end else begin
              kij_d   = kij_q + KIJ_W'(1);
              state_d = S_LOAD_W;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        compute_done = 1'b1;
        kij_d        = '0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    psum_wr = ofifo_rd;
  end

`ifdef SYSTOLIC_SEQ_PERF_EN
  // Saturating count of effective stall cycles; restarts on each accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (latch) begin
      stall_cycles <= '0;
    end else if (stall_eff && busy && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Parametrised sequencer for the ROW x COL weight-stationary systolic array.
- For each of KIJ_LEN kernel positions it runs, in order: weight load, one bubble cycle, activation streaming, array drain, and read-out of partial sums into psum SRAM.
- Adds over the previous controller: explicit FSM, start/busy/done handshake, generated SRAM addresses, back-pressure stall, and kij index output.
- Sits between the top-level host FSM and the L0/array/OFIFO/psum-SRAM datapath.

Parameters:
- ROW, 4, array rows; weight-load length per kij.
- COL, 4, array columns; contributes to drain length.
- NUM_INP, 8, activation vectors streamed per kij; also outputs read per kij.
- KIJ_LEN, 9, kernel positions per compute.
- ADDR_W, 11, SRAM address width.
- Derived: CNT_W = $clog2(max(ROW+COL, NUM_INP)+1); KIJ_W = $clog2(KIJ_LEN).

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high reset.
- start, input, 1, request to begin; sampled only in IDLE.
- stall, input, 1, downstream back-pressure; freezes stallable states.
- w_base, input, ADDR_W, weight SRAM base address; latched on start accept.
- act_base, input, ADDR_W, activation SRAM base address; latched on start accept.
- busy, output, 1, high from LOAD_W entry until DONE exit.
- sram_rd, output, 1, activation/weight SRAM read enable.
- sram_addr, output, ADDR_W, SRAM read address.
- inst_w, output, 2, array instruction: 01 = load kernel, 10 = execute, 00 = idle.
- mode, output, 1, 0 = weight path, 1 = activation path.
- ofifo_rd, output, 1, OFIFO pop.
- psum_wr, output, 1, psum SRAM write enable; equals ofifo_rd.
- psum_addr, output, ADDR_W, equals kij*NUM_INP + cnt.
- kij, output, KIJ_W, current kernel position.
- iter_done, output, 1, one-cycle pulse at the end of each kij.
- compute_done, output, 1, one-cycle pulse after the last kij.

Behaviour:
- Registers: state, cnt (CNT_W), kij (KIJ_W), latched bases.
- Outputs are combinational decode of state, cnt, kij and stall; there is no combinational path from start.
- Reset:
  - state = IDLE; cnt = 0; kij = 0.
  - All outputs 0 and busy = 0.
  - Reset mid-operation aborts immediately, with no done pulses.
- IDLE:
  - All enables 0; inst_w = 00.
  - On start = 1: latch bases; kij = 0; cnt = 0; go to LOAD_W next cycle.
- LOAD_W (ROW cycles):
  - sram_rd = 1; inst_w = 01; mode = 0; sram_addr = w_base + kij*ROW + cnt.
  - When cnt = ROW-1: cnt = 0 and go to GAP.
- GAP (1 cycle):
  - sram_rd = 0; inst_w = 01; mode = 0.
  - Go to EXEC.
- EXEC (NUM_INP cycles):
  - sram_rd = 1; inst_w = 10; mode = 1; sram_addr = act_base + cnt.
  - When cnt = NUM_INP-1: go to DRAIN.
- DRAIN (ROW+COL cycles):
  - Enables 0; inst_w = 00; mode holds 1.
  - When cnt = ROW+COL-1: go to RDOUT.
- RDOUT (NUM_INP cycles):
  - ofifo_rd = psum_wr = 1.
  - When cnt = NUM_INP-1: iter_done = 1 in this same cycle.
  - If kij = KIJ_LEN-1, go to DONE; else kij increments and go to LOAD_W.
- DONE (1 cycle):
  - compute_done = 1; busy = 1; kij = 0.
  - Go to IDLE.
- Stall:
  - Applies in LOAD_W, EXEC and RDOUT only.
  - While stall = 1: cnt, kij and state hold; sram_rd, ofifo_rd and psum_wr are forced 0; inst_w = 00.
  - Stall is ignored in GAP, DRAIN, IDLE and DONE.
  - If stall coincides with a terminal count, no transition and no iter_done until stall drops.
- start while busy is ignored; the latched bases do not change.
- Unstalled timing:
  - Cycles per kij: T = 2*ROW + COL + 1 + 2*NUM_INP (29 at defaults).
  - Start accepted in cycle 0 → first iter_done in cycle T, compute_done in cycle KIJ_LEN*T + 1 (262), IDLE in cycle 263.
- Address arithmetic is modulo 2^ADDR_W and wraps silently.

Optional Feature:
- Macro: SYSTOLIC_SEQ_PERF_EN.
- When defined:
  - Adds output stall_cycles [31:0].
  - Counts cycles where busy = 1 and stall is effective.
  - Clears to 0 on start accept; saturates at 0xFFFFFFFF; holds its value in IDLE; reset value 0.
- When undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Defaults, w_base = 0x100, act_base = 0x040, start pulse, no stall.
  - Check: sram_addr 0x100–0x103 (inst_w 01) → one gap → 0x040–0x047 (inst_w 10) → 8 idle → 8 psum_wr at psum_addr 0–7.
  - Check: iter_done at cycle 29; compute_done at cycle 262.
- kij sequencing: in kij = 2, weight addresses are 0x108–0x10B and psum_addr is 16–23; the last kij = 8 writes psum_addr 64–71.
- stall high for 3 cycles at EXEC cnt = 5.
  - Check: sram_rd = 0 and inst_w = 00 for those cycles; addr 0x045 is reissued afterwards.
  - Check: all later events slip by 3 cycles; stall_cycles = 3 with PERF_EN.
- start asserted again at cycle 50 with new bases → ignored; addresses are unchanged and busy stays 1.
- reset asserted in DRAIN of kij = 4 → next cycle busy = 0 and kij = 0, with no iter_done or compute_done pulse; a fresh start runs all 9 kij.
- ROW = COL = 8, NUM_INP = 16, KIJ_LEN = 1 → T = 57; a single iter_done at cycle 57, then compute_done at cycle 58.
